// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder built from one-bit full-adder cells.
// The sum and carry out are purely combinational; a separate enable-qualified
// register stage keeps a copy of the last captured result with a valid flag.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             en,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic [WIDTH-1:0] s_q,
  output logic             c_out_q,
  output logic             valid_q
);

  // carry[i] is the carry into bit i; carry[WIDTH] leaves the MSB.
  logic [WIDTH:0] carry;

  if (WIDTH < 1) begin : g_width_check
    $error("full_adder: WIDTH must be at least 1");
  end

  assign carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign s[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
  end

  assign c_out = carry[WIDTH];

  // Capture the combinational result when enabled; valid_q marks a fresh capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      c_out_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en;
      if (en) begin
        s_q     <= s;
        c_out_q <= c_out;
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder at WIDTH=1 and WIDTH=4.
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a1, b1, c1, en1;
  logic       s1, co1, s1_q, co1_q, v1_q;

  logic [3:0] a4, b4;
  logic       c4, en4;
  logic [3:0] s4, s4_q;
  logic       co4, co4_q, v4_q;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic a;
    logic b;
    logic c;
    logic [1:0] exp;  // {c_out, s}
  } vec_t;

  vec_t tt [8];

  logic [3:0] m_s_q;
  logic       m_co_q, m_v_q;
  logic [4:0] sum;

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c_in(c1), .en(en1),
    .s(s1), .c_out(co1), .s_q(s1_q), .c_out_q(co1_q), .valid_q(v1_q)
  );

  full_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c_in(c4), .en(en4),
    .s(s4), .c_out(co4), .s_q(s4_q), .c_out_q(co4_q), .valid_q(v4_q)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // listed as a b c_in -> {c_out,s}
    tt[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
    tt[1] = '{1'b1, 1'b0, 1'b0, 2'b01};
    tt[2] = '{1'b0, 1'b1, 1'b0, 2'b01};
    tt[3] = '{1'b1, 1'b1, 1'b0, 2'b10};
    tt[4] = '{1'b0, 1'b0, 1'b1, 2'b01};
    tt[5] = '{1'b1, 1'b0, 1'b1, 2'b10};
    tt[6] = '{1'b0, 1'b1, 1'b1, 2'b10};
    tt[7] = '{1'b1, 1'b1, 1'b1, 2'b11};

    a1 = 0; b1 = 0; c1 = 0; en1 = 0;
    a4 = 0; b4 = 0; c4 = 0; en4 = 0;

    // Reset state
    #12;
    check("rst s1_q", {7'b0, s1_q}, 8'h0);
    check("rst co1_q", {7'b0, co1_q}, 8'h0);
    check("rst v1_q", {7'b0, v1_q}, 8'h0);
    check("rst s4_q", {4'b0, s4_q}, 8'h0);
    check("rst v4_q", {7'b0, v4_q}, 8'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 truth table, 100 ns per vector (a fastest, c_in slowest)
    for (int i = 0; i < 8; i++) begin
      a1 = tt[i].a; b1 = tt[i].b; c1 = tt[i].c;
      #1;
      check($sformatf("tt%0d", i), {6'b0, co1, s1}, {6'b0, tt[i].exp});
      #99;
    end

    // Register latency and hold
    @(negedge clk);
    a1 = 1; b1 = 1; c1 = 0; en1 = 1;
    @(negedge clk);
    check("lat s1_q", {7'b0, s1_q}, 8'h0);
    check("lat co1_q", {7'b0, co1_q}, 8'h1);
    check("lat v1_q", {7'b0, v1_q}, 8'h1);
    en1 = 0; a1 = 0; b1 = 1; c1 = 0;
    @(negedge clk);
    check("hold s1_q", {7'b0, s1_q}, 8'h0);
    check("hold co1_q", {7'b0, co1_q}, 8'h1);
    check("hold v1_q", {7'b0, v1_q}, 8'h0);
    check("hold comb s1", {7'b0, s1}, 8'h1);

    // Async reset between clock edges
    a1 = 1; b1 = 0; c1 = 0; en1 = 1;
    @(negedge clk);
    check("pre-rst s1_q", {7'b0, s1_q}, 8'h1);
    check("pre-rst v1_q", {7'b0, v1_q}, 8'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst s1_q", {7'b0, s1_q}, 8'h0);
    check("arst co1_q", {7'b0, co1_q}, 8'h0);
    check("arst v1_q", {7'b0, v1_q}, 8'h0);
    check("arst comb s1", {7'b0, s1}, 8'h1);
    b1 = 1;
    #1;
    check("arst comb track", {6'b0, co1, s1}, 8'h2);
    @(posedge clk);
    #1;
    check("arst held s1_q", {7'b0, s1_q}, 8'h0);
    check("arst held v1_q", {7'b0, v1_q}, 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 1; b1 = 1; c1 = 1; en1 = 1;
    @(negedge clk);
    check("post-rst s1_q", {7'b0, s1_q}, 8'h1);
    check("post-rst co1_q", {7'b0, co1_q}, 8'h1);
    check("post-rst v1_q", {7'b0, v1_q}, 8'h1);
    en1 = 0;

    // WIDTH=4 boundaries
    a4 = 4'hF; b4 = 4'h0; c4 = 1; #1;
    check("w4 ripple", {3'b0, co4, s4}, 8'h10);
    a4 = 4'hA; b4 = 4'h5; c4 = 0; #1;
    check("w4 A+5", {3'b0, co4, s4}, 8'h0F);
    a4 = 4'hF; b4 = 4'hF; c4 = 1; #1;
    check("w4 all ones", {3'b0, co4, s4}, 8'h1F);
    a4 = 4'h0; b4 = 4'h0; c4 = 0; #1;
    check("w4 all zero", {3'b0, co4, s4}, 8'h00);

    // WIDTH=4 random with register model; en4 has stayed 0 since the last reset
    m_s_q = 4'h0; m_co_q = 1'b0; m_v_q = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check("rnd s4_q", {4'b0, s4_q}, {4'b0, m_s_q});
      check("rnd co4_q", {7'b0, co4_q}, {7'b0, m_co_q});
      check("rnd v4_q", {7'b0, v4_q}, {7'b0, m_v_q});
      a4  = 4'($urandom_range(0, 15));
      b4  = 4'($urandom_range(0, 15));
      c4  = 1'($urandom_range(0, 1));
      en4 = 1'($urandom_range(0, 1));
      #1;
      sum = {1'b0, a4} + {1'b0, b4} + {4'b0, c4};
      check("rnd comb", {3'b0, co4, s4}, {3'b0, sum});
      if (en4) begin
        m_s_q  = sum[3:0];
        m_co_q = sum[4];
      end
      m_v_q = en4;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Single-bit full adder, scalable to a WIDTH-bit ripple-carry adder: s = a + b + c_in, with carry out.
- Provides a purely combinational result path (s, c_out), the primary exhaustive-truth-table target.
- Also provides a registered copy of the result (s_q, c_out_q, valid_q) for pipelined use in datapaths.
- Leaf arithmetic cell used by wider adders and ALU slices.

Parameters:
- WIDTH, 1, operand width in bits. Must be >= 1. The ripple chain is built from WIDTH one-bit full-adder cells.

Ports:
- clk  input  1  rising-edge clock, used by the output register stage only.
- rst_n  input  1  asynchronous active-low reset, used by the output register stage only.
- a  input  WIDTH  addend A.
- b  input  WIDTH  addend B.
- c_in  input  1  carry into bit 0.
- en  input  1  register-stage capture enable.
- s  output  WIDTH  combinational sum bits.
- c_out  output  1  combinational carry out of the MSB.
- s_q  output  WIDTH  registered sum.
- c_out_q  output  1  registered carry out.
- valid_q  output  1  registered result is valid.

Behaviour:
- Cell equations, bit i with carry-in c[i]:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i])
  - c[0] = c_in; c_out = c[WIDTH].
- Arithmetic identity: {c_out, s} == a + b + c_in, computed at WIDTH+1 bits with no truncation. Unsigned; there is no separate overflow flag.
- s and c_out are purely combinational:
  - zero cycles of latency, no dependence on clk, rst_n or en;
  - they settle within the same simulation timestep as any input change;
  - no latches and no X propagation for known inputs.
- Register stage:
  - on a rising clk edge with en=1: s_q <= s, c_out_q <= c_out, valid_q <= 1;
  - on a rising clk edge with en=0: s_q and c_out_q hold; valid_q <= 0.
- Registered-path latency: 1 cycle from the en-qualified sample.
- Reset:
  - rst_n=0 forces s_q=0, c_out_q=0, valid_q=0 immediately, independent of clk;
  - the outputs hold these values while rst_n is low;
  - the first capture happens at the first rising clk edge after rst_n deasserts, provided en=1.
- Reset asserted mid-operation clears the register stage only; the combinational s and c_out keep tracking the inputs throughout reset.
- Boundary conditions:
  - all-ones inputs (a=b=all 1s, c_in=1) give s = all 1s, c_out=1;
  - all-zero inputs give s=0, c_out=0;
  - carry ripple from bit 0 to c_out must be correct when a=all 1s, b=0, c_in=1: result s=0, c_out=1.
- Inputs changing on the same edge as capture: the value sampled is the pre-edge combinational result, per standard flop semantics.

Test Plan:
- WIDTH=1 exhaustive truth table, with c_in toggling every 400 ns, b every 200 ns, a every 100 ns, over 800 ns. Required {c_out,s}:
  - 000->00, 100->01, 010->01, 110->10 (listed as a b c_in);
  - 001->01, 101->10, 011->10, 111->11.
- Async reset: drive rst_n=0 between clk edges while s_q=1 and valid_q=1 -> s_q, c_out_q and valid_q read 0 at once; s still equals a^b^c_in.
- Register latency, WIDTH=1, en=1: apply a=1, b=1, c_in=0 before an edge -> after that edge s_q=0, c_out_q=1, valid_q=1. With en=0 on the next edge -> s_q and c_out_q hold, valid_q=0.
- WIDTH=4 full ripple: a=4'hF, b=4'h0, c_in=1 -> s=4'h0, c_out=1. Then a=4'hA, b=4'h5, c_in=0 -> s=4'hF, c_out=0.
- WIDTH=4 random: 1000 random vectors of a, b, c_in -> {c_out,s} equals a+b+c_in every vector; s_q and c_out_q match the previous en-qualified combinational result.
